// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped responder: region codes,
// timer register offsets and timer control bit positions.
package mmio_pkg;

    typedef enum logic [3:0] {
        REG_RAM   = 4'h0,
        REG_LEDR  = 4'h1,
        REG_HEX   = 4'h2,
        REG_SW    = 4'h3,
        REG_TIMER = 4'h4
    } region_e;

    typedef enum logic [1:0] {
        TMR_CTRL   = 2'd0,
        TMR_LOAD   = 2'd1,
        TMR_COUNT  = 2'd2,
        TMR_STATUS = 2'd3
    } tmr_off_e;

    localparam int unsigned CTRL_RUN  = 0;
    localparam int unsigned CTRL_AUTO = 1;

    // Active-low segments: all ones is a blank digit
    localparam logic [6:0] HEX_BLANK  = 7'h7F;
    localparam logic [2:0] HEX_DIGITS = 3'd6;

endpackage

// File: rtl/mmio_timer.sv
// Countdown timer for region 0x4: CTRL {autoreload,run}, LOAD, COUNT and a
// sticky timeout flag in STATUS. Only instantiated when MMIO_TIMER_EN is set.
module mmio_timer
    import mmio_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        wr_en,
    input  tmr_off_e    off,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data
);

    logic [1:0]  ctrl_q, ctrl_d;
    logic [15:0] load_q, load_d;
    logic [15:0] count_q, count_d;
    logic        to_q, to_d;
    logic        to_set;

    // Countdown/expiry first, then processor writes override; a timeout set wins over a STATUS clear
    always_comb begin
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        to_d    = to_q;
        to_set  = 1'b0;

        if (ctrl_q[CTRL_RUN]) begin
            if (count_q != '0) begin
                count_d = count_q - 16'd1;
            end else begin
                to_set = 1'b1;
                if (ctrl_q[CTRL_AUTO]) begin
                    count_d = load_q;
                end else begin
                    ctrl_d[CTRL_RUN] = 1'b0;
                    count_d          = '0;
                end
            end
        end

        if (wr_en) begin
            case (off)
                TMR_CTRL: begin
                    ctrl_d  = wr_data[1:0];
                    count_d = count_q;
                end
                TMR_LOAD:   load_d  = wr_data;
                TMR_COUNT:  count_d = wr_data;
                TMR_STATUS: to_d    = 1'b0;
                default:    ;
            endcase
        end

        if (to_set) begin
            to_d = 1'b1;
        end
    end

    // Timer register bank
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ctrl_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            to_q    <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            to_q    <= to_d;
        end
    end

    // Read mux on the register offset
    always_comb begin
        rd_data = '0;
        case (off)
            TMR_CTRL:   rd_data = {14'b0, ctrl_q};
            TMR_LOAD:   rd_data = load_q;
            TMR_COUNT:  rd_data = count_q;
            TMR_STATUS: rd_data = {15'b0, to_q};
            default:    rd_data = '0;
        endcase
    end

endmodule

// File: rtl/mmio_responder.sv
// Memory-side responder for the lab processor: on-chip RAM, LED and
// 7-segment registers, synchronized switches and (with MMIO_TIMER_EN
// defined) a countdown timer at region 0x4. Read data on DIN is
// registered, giving exactly one cycle of latency.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int unsigned RAM_AW = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] ADDR,
    input  logic [15:0] DOUT,
    input  logic        W,
    output logic [15:0] DIN,
    input  logic [9:0]  SW,
    output logic [9:0]  LEDR,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);

    region_e           region;
    logic [RAM_AW-1:0] ram_idx;
    logic [2:0]        hex_sel;
    logic [15:0]       mem [0:(1 << RAM_AW) - 1];
    logic [6:0]        hex_q [0:5];
    logic [9:0]        sw_meta;
    logic [9:0]        sw_sync;
    logic [15:0]       rd_data;
    logic [15:0]       tmr_rdata;
    logic              unused_addr;

    assign region      = region_e'(ADDR[15:12]);
    assign ram_idx     = ADDR[RAM_AW-1:0];
    assign hex_sel     = ADDR[2:0];
    assign unused_addr = ^ADDR;

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

`ifdef MMIO_TIMER_EN
    mmio_timer u_timer (
        .Clock   (Clock),
        .Reset   (Reset),
        .wr_en   (W && (region == REG_TIMER)),
        .off     (tmr_off_e'(ADDR[1:0])),
        .wr_data (DOUT),
        .rd_data (tmr_rdata)
    );
`else
    assign tmr_rdata = '0;
`endif

    // RAM write port; contents are deliberately not reset
    always_ff @(posedge Clock) begin
        if (W && (region == REG_RAM)) begin
            mem[ram_idx] <= DOUT;
        end
    end

    // LED and 7-segment output registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            LEDR <= '0;
            for (int unsigned i = 0; i < 6; i++) begin
                hex_q[i] <= HEX_BLANK;
            end
        end else if (W) begin
            if (region == REG_LEDR) begin
                LEDR <= DOUT[9:0];
            end
            if ((region == REG_HEX) && (hex_sel < HEX_DIGITS)) begin
                hex_q[hex_sel] <= DOUT[6:0];
            end
        end
    end

    // Two-flop synchronizer for the asynchronous switches
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
        end
    end

    // Read decode of the current address; RAM reads see pre-write data (read-first)
    always_comb begin
        rd_data = '0;
        case (region)
            REG_RAM:  rd_data = mem[ram_idx];
            REG_LEDR: rd_data = {6'b0, LEDR};
            REG_HEX: begin
                if (hex_sel < HEX_DIGITS) begin
                    rd_data = {9'b0, hex_q[hex_sel]};
                end
            end
            REG_SW:    rd_data = {6'b0, sw_sync};
            REG_TIMER: rd_data = tmr_rdata;
            default:   rd_data = '0;
        endcase
    end

    // Registered read data for the processor's memory wait cycle
    always_ff @(posedge Clock) begin
        if (Reset) begin
            DIN <= '0;
        end else begin
            DIN <= rd_data;
        end
    end

endmodule
